// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: loads an mm:ss BCD setpoint, counts it down on the
// 1 Hz tick through RUN/PAUSE, then rings the buzzer for RING_SECS ticks.
module countdown_timer_ctrl #(
  parameter int unsigned RING_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [2:0] set_mt,
  input  logic [3:0] set_mu,
  input  logic [2:0] set_st,
  input  logic [3:0] set_su,
  output logic [2:0] rem_mt,
  output logic [3:0] rem_mu,
  output logic [2:0] rem_st,
  output logic [3:0] rem_su,
  output logic [1:0] state,
  output logic       running,
  output logic       buzzer,
  output logic       done
);

  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    RING  = 2'b11
  } state_t;

  state_t        state_q, state_n;
  logic [2:0]    mt_n, st_n, dmt, dst;
  logic [3:0]    mu_n, su_n, dmu, dsu;
  logic [CW-1:0] ring_cnt, cnt_n, cnt_inc;
  logic          done_n, set_ok, rem_zero, dec_zero;

  assign set_ok = (set_mt <= 3'd5) && (set_mu <= 4'd9) && (set_st <= 3'd5) &&
                  (set_su <= 4'd9) &&
                  ((set_mt != 3'd0) || (set_mu != 4'd0) || (set_st != 3'd0) || (set_su != 4'd0));
  assign rem_zero = (rem_mt == 3'd0) && (rem_mu == 4'd0) && (rem_st == 3'd0) && (rem_su == 4'd0);
  assign dec_zero = (dmt == 3'd0) && (dmu == 4'd0) && (dst == 3'd0) && (dsu == 4'd0);
  assign cnt_inc  = ring_cnt + CW'(1);

  // One-second BCD decrement with ripple borrow; saturates at 00:00
  always_comb begin
    dmt = rem_mt;
    dmu = rem_mu;
    dst = rem_st;
    dsu = rem_su;
    if (!rem_zero) begin
      if (rem_su != 4'd0) begin
        dsu = rem_su - 4'd1;
      end else begin
        dsu = 4'd9;
        if (rem_st != 3'd0) begin
          dst = rem_st - 3'd1;
        end else begin
          dst = 3'd5;
          if (rem_mu != 4'd0) begin
            dmu = rem_mu - 4'd1;
          end else begin
            dmu = 4'd9;
            dmt = rem_mt - 3'd1;
          end
        end
      end
    end
  end

  // Next-state logic; priority clear > stop > start > tick
  always_comb begin
    state_n = state_q;
    mt_n    = rem_mt;
    mu_n    = rem_mu;
    st_n    = rem_st;
    su_n    = rem_su;
    cnt_n   = ring_cnt;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        mt_n = set_mt;
        mu_n = set_mu;
        st_n = set_st;
        su_n = set_su;
        if (!clear && !stop && start && set_ok) state_n = RUN;
      end
      RUN: begin
        if (clear) begin
          state_n = IDLE;
        end else if (stop) begin
          state_n = PAUSE;
        end else if (tick_1hz) begin
          mt_n = dmt;
          mu_n = dmu;
          st_n = dst;
          su_n = dsu;
          if (dec_zero) begin
            state_n = RING;
            done_n  = 1'b1;
            cnt_n   = '0;
          end
        end
      end
      PAUSE: begin
        if (clear)                state_n = IDLE;
        else if (!stop && start)  state_n = RUN;
      end
      RING: begin
        mt_n = 3'd0;
        mu_n = 4'd0;
        st_n = 3'd0;
        su_n = 4'd0;
        if (clear || stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (tick_1hz) begin
          if (cnt_inc >= CW'(RING_SECS)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_mt   <= 3'd0;
      rem_mu   <= 4'd0;
      rem_st   <= 3'd0;
      rem_su   <= 4'd0;
      ring_cnt <= '0;
      running  <= 1'b0;
      buzzer   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      rem_mt   <= mt_n;
      rem_mu   <= mu_n;
      rem_st   <= st_n;
      rem_su   <= su_n;
      ring_cnt <= cnt_n;
      running  <= (state_n == RUN);
      buzzer   <= (state_n == RING);
      done     <= done_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: expected output vectors are queued as
// stimulus is driven and compared against captured DUT outputs per scenario.
module tb_countdown_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, start, stop, clear;
  logic [2:0] set_mt, set_st, rem_mt, rem_st;
  logic [3:0] set_mu, set_su, rem_mu, rem_su;
  logic [1:0] state;
  logic       running, buzzer, done;

  int checks = 0;
  int fails  = 0;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  string       nm_q[$];

  countdown_timer_ctrl #(.RING_SECS(10)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .stop(stop), .clear(clear),
    .set_mt(set_mt), .set_mu(set_mu), .set_st(set_st), .set_su(set_su),
    .rem_mt(rem_mt), .rem_mu(rem_mu), .rem_st(rem_st), .rem_su(rem_su),
    .state(state), .running(running), .buzzer(buzzer), .done(done)
  );

  always #5 clk = ~clk;

  // Expected vector: {state, running, buzzer, done, mt, mu, st, su}
  function automatic logic [18:0] mk(input logic [1:0] s, input logic d, input logic [2:0] a,
                                     input logic [3:0] b, input logic [2:0] c, input logic [3:0] e);
    return {s, (s == 2'b01), (s == 2'b11), d, a, b, c, e};
  endfunction

  function automatic logic [18:0] sample();
    return {state, running, buzzer, done, rem_mt, rem_mu, rem_st, rem_su};
  endfunction

  task automatic expect_now(input string nm, input logic [18:0] e);
    exp_q.push_back(e);
    obs_q.push_back(sample());
    nm_q.push_back(nm);
  endtask

  task automatic setp(input logic [2:0] a, input logic [3:0] b, input logic [2:0] c, input logic [3:0] d);
    set_mt = a; set_mu = b; set_st = c; set_su = d;
  endtask

  task automatic step(input logic s, input logic p, input logic c, input logic t);
    start = s; stop = p; clear = c; tick_1hz = t;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [18:0] e, o;
    string n;
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
    setp(3'd1, 4'd2, 3'd3, 4'd4);
    #2;
    expect_now("reset_hold", mk(2'b00, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0));
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);
    expect_now("idle_load", mk(2'b00, 1'b0, 3'd1, 4'd2, 3'd3, 4'd4));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_countdown();
    logic [18:0] e, o;
    string n;
    setp(3'd0, 4'd0, 3'd0, 4'd3);
    step(0, 0, 0, 0);
    expect_now("cd_idle", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd3));
    step(1, 0, 0, 0);
    expect_now("cd_start", mk(2'b01, 0, 3'd0, 4'd0, 3'd0, 4'd3));
    step(0, 0, 0, 1);
    expect_now("cd_t1", mk(2'b01, 0, 3'd0, 4'd0, 3'd0, 4'd2));
    step(0, 0, 0, 1);
    expect_now("cd_t2", mk(2'b01, 0, 3'd0, 4'd0, 3'd0, 4'd1));
    step(0, 0, 0, 1);
    expect_now("cd_ring", mk(2'b11, 1, 3'd0, 4'd0, 3'd0, 4'd0));
    step(0, 0, 0, 0);
    expect_now("cd_done_drop", mk(2'b11, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    step(1, 0, 0, 0);
    expect_now("cd_ring_start_ign", mk(2'b11, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    for (int i = 1; i <= 9; i++) step(0, 0, 0, 1);
    expect_now("cd_ring_9", mk(2'b11, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    step(0, 0, 0, 1);
    expect_now("cd_ring_end", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    step(0, 0, 0, 0);
    expect_now("cd_reload", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd3));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_borrow();
    logic [18:0] e, o;
    string n;
    setp(3'd1, 4'd0, 3'd0, 4'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_now("br_0959", mk(2'b01, 0, 3'd0, 4'd9, 3'd5, 4'd9));
    step(0, 0, 0, 1);
    expect_now("br_0958", mk(2'b01, 0, 3'd0, 4'd9, 3'd5, 4'd8));
    step(0, 0, 1, 0);
    expect_now("br_clear", mk(2'b00, 0, rem_mt, rem_mu, rem_st, rem_su) & 19'h7c000 | (sample() & 19'h03fff));
    step(0, 0, 0, 0);
    expect_now("br_reload", mk(2'b00, 0, 3'd1, 4'd0, 3'd0, 4'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_pause();
    logic [18:0] e, o;
    string n;
    setp(3'd0, 4'd1, 3'd3, 4'd1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_now("pa_0130", mk(2'b01, 0, 3'd0, 4'd1, 3'd3, 4'd0));
    step(0, 1, 0, 1);
    expect_now("pa_stop_tick", mk(2'b10, 0, 3'd0, 4'd1, 3'd3, 4'd0));
    step(0, 0, 0, 1);
    expect_now("pa_tick_ign", mk(2'b10, 0, 3'd0, 4'd1, 3'd3, 4'd0));
    step(1, 0, 0, 1);
    expect_now("pa_resume", mk(2'b01, 0, 3'd0, 4'd1, 3'd3, 4'd0));
    step(0, 0, 0, 1);
    expect_now("pa_0129", mk(2'b01, 0, 3'd0, 4'd1, 3'd2, 4'd9));
    setp(3'd5, 4'd5, 3'd5, 4'd5);
    step(0, 0, 0, 1);
    expect_now("pa_set_ign", mk(2'b01, 0, 3'd0, 4'd1, 3'd2, 4'd8));
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    expect_now("pa_clear_reload", mk(2'b00, 0, 3'd5, 4'd5, 3'd5, 4'd5));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_invalid();
    logic [18:0] e, o;
    string n;
    setp(3'd0, 4'd0, 3'd0, 4'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_now("inv_zero", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    setp(3'd0, 4'd1, 3'd0, 4'hA);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_now("inv_su_a", mk(2'b00, 0, 3'd0, 4'd1, 3'd0, 4'hA));
    setp(3'd6, 4'd0, 3'd0, 4'd1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    expect_now("inv_mt_6", mk(2'b00, 0, 3'd6, 4'd0, 3'd0, 4'd1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_ring_stop();
    logic [18:0] e, o;
    string n;
    setp(3'd0, 4'd0, 3'd0, 4'd1);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    expect_now("rs_ring", mk(2'b11, 1, 3'd0, 4'd0, 3'd0, 4'd0));
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    expect_now("rs_stop", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    step(0, 0, 0, 0);
    expect_now("rs_reload", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [18:0] e, o;
    string n;
    setp(3'd0, 4'd5, 3'd0, 4'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_now("ar_run", mk(2'b01, 0, 3'd0, 4'd5, 3'd0, 4'd0));
    #2;
    rst = 1'b1;
    #1;
    expect_now("ar_async", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    @(negedge clk);
    rst = 1'b0;
    setp(3'd0, 4'd0, 3'd0, 4'd5);
    step(0, 0, 0, 0);
    expect_now("ar_idle", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd5));
    step(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1);
    expect_now("ar_0001", mk(2'b01, 0, 3'd0, 4'd0, 3'd0, 4'd1));
    step(0, 0, 0, 1);
    expect_now("ar_ring", mk(2'b11, 1, 3'd0, 4'd0, 3'd0, 4'd0));
    step(0, 0, 1, 0);
    expect_now("ar_clear_ring", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] e, o;
    string n;
    setp(3'd0, 4'd0, 3'd1, 4'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    expect_now("bb_restart", mk(2'b01, 0, 3'd0, 4'd0, 3'd1, 4'd0));
    step(0, 0, 0, 1);
    expect_now("bb_0009", mk(2'b01, 0, 3'd0, 4'd0, 3'd0, 4'd9));
    step(1, 1, 1, 1);
    expect_now("bb_all_clear", mk(2'b00, 0, 3'd0, 4'd0, 3'd0, 4'd9));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h expected %h", n, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_invalid();
    test_ring_stop();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
